// File: rtl/ysyx_25020037_icache_pkg.sv
// Shared configuration for the instruction cache: default geometry and FSM encodings.
package ysyx_25020037_icache_pkg;

  localparam int ICACHE_NUM_LINES  = 16;
  localparam int ICACHE_BLOCK_SIZE = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

endpackage

// File: rtl/ysyx_25020037_icache_array.sv
// Tag and data storage for the icache: combinational read port, one synchronous write port.
module ysyx_25020037_icache_array
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int NUM_LINES = ICACHE_NUM_LINES,
  parameter int INDEX_W   = $clog2(ICACHE_NUM_LINES),
  parameter int TAG_W     = 32 - $clog2(ICACHE_NUM_LINES) - $clog2(ICACHE_BLOCK_SIZE),
  parameter int LINE_W    = ICACHE_BLOCK_SIZE * 8
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] ridx,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rdata,
  input  logic               wen,
  input  logic [INDEX_W-1:0] widx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wdata
);

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_W-1:0] data_mem [NUM_LINES];

  // No reset: contents are only trusted when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wen) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rtag  = tag_mem[ridx];
  assign rdata = data_mem[ridx];

endmodule

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped read-only instruction cache with combinational lookup and IFU-driven block refill.
//   state | meaning
//   IDLE  | lookups served; a miss raises mem_req and starts a refill on the next edge
//   FILL  | waiting for the IFU to return the block for the latched fill address
module ysyx_25020037_icache
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int BLOCK_SIZE = ICACHE_BLOCK_SIZE,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             icache_addr,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    flush,
  output logic [31:0]             perf_miss_cnt
);

  localparam int OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int BLK_W    = 32 - OFFSET_W;
  localparam int LINE_W   = BLOCK_SIZE * 8;

  logic [0:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [BLK_W-1:0]     fill_blk;
  logic [INDEX_W-1:0]   idx;
  logic [INDEX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]     tag;
  logic [TAG_W-1:0]     fill_tag;
  logic [TAG_W-1:0]     line_tag;
  logic [LINE_W-1:0]    line_data;
  logic [31:0]          hit_word;
  logic                 idle;
  logic                 fill_done;
  logic                 unused_offset;

  assign idx      = icache_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag      = icache_addr[31:INDEX_W+OFFSET_W];
  assign fill_idx = fill_blk[INDEX_W-1:0];
  assign fill_tag = fill_blk[BLK_W-1:INDEX_W];

  assign unused_offset = ^icache_addr[OFFSET_W-1:0];

  ysyx_25020037_icache_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_array (
    .clk   (clk),
    .ridx  (idx),
    .rtag  (line_tag),
    .rdata (line_data),
    .wen   (fill_done),
    .widx  (fill_idx),
    .wtag  (fill_tag),
    .wdata (mem_data)
  );

  generate
    if (BLOCK_SIZE == 4) begin : g_single_word
      assign hit_word = line_data;
    end else begin : g_multi_word
      logic [OFFSET_W-3:0] wsel;
      assign wsel     = icache_addr[OFFSET_W-1:2];
      assign hit_word = line_data[wsel*32 +: 32];
    end
  endgenerate

  assign idle         = (state == IDLE);
  assign icache_hit   = idle & valid[idx] & (line_tag == tag);
  assign icache_ready = idle;
  assign icache_data  = icache_hit ? hit_word : 32'h0;
  assign mem_req      = idle & ~icache_hit;
  assign mem_addr     = idle ? {icache_addr[31:OFFSET_W], {OFFSET_W{1'b0}}}
                             : {fill_blk, {OFFSET_W{1'b0}}};
  assign fill_done    = (state == FILL) & mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      fill_blk      <= '0;
      perf_miss_cnt <= 32'h0;
    end else begin
      if (state == IDLE) begin
        if (mem_req) begin
          state         <= FILL;
          fill_blk      <= icache_addr[31:OFFSET_W];
          perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
      end else if (mem_ready) begin
        state <= IDLE;
      end
      // Install after the flush clear so a same-edge fill keeps its line valid.
      if (flush) valid <= '0;
      if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

endmodule

// File: doc/ysyx_25020037_icache.md
Name: ysyx_25020037_icache

Overview:
Direct-mapped, read-only instruction cache that sits between the IFU and its AXI fetch path. It answers the IFU's per-cycle lookup with combinational hit/data. On a miss it asks the IFU to fetch one aligned block over AXI, then installs the block when the IFU returns it. A fence_i-driven flush invalidates all lines.

Parameters:
BLOCK_SIZE, 4, line size in bytes; power of two, >= 4; must match the IFU's BLOCK_SIZE.
NUM_LINES, 16, number of lines; power of two, >= 2.
Derived: OFFSET_W = log2(BLOCK_SIZE); INDEX_W = log2(NUM_LINES); TAG_W = 32 - INDEX_W - OFFSET_W.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  reset, asynchronous, active-high.
icache_addr  in  32  fetch PC from the IFU; held stable by the IFU while a miss is outstanding.
icache_data  out  32  word of the hit line selected by icache_addr[OFFSET_W-1:2]; 0 when not hitting.
icache_hit  out  1  combinational hit: state==IDLE & valid[idx] & tag[idx]==addr tag.
icache_ready  out  1  1 when state==IDLE.
mem_req  out  1  combinational refill request: state==IDLE & ~icache_hit.
mem_addr  out  32  block-aligned address: {icache_addr[31:OFFSET_W], 0} while IDLE, latched fill address while FILL.
mem_data  in  BLOCK_SIZE*8  refill block from the IFU; word k is at bits [32k+31:32k].
mem_ready  in  1  refill block valid; the IFU holds it high until it consumes a hit.
flush  in  1  single-cycle pulse; invalidates every line.
perf_miss_cnt  out  32  number of refills started since reset; wraps modulo 2^32.

Behaviour:
- Reset (async, rst=1): state=IDLE, all valid bits 0, fill address 0, perf_miss_cnt=0. Outputs follow: icache_hit=0, icache_ready=1, and mem_req=1 whenever deasserted. Tag and data arrays are not reset.
- Address split: tag=addr[31:INDEX_W+OFFSET_W], idx=addr[INDEX_W+OFFSET_W-1:OFFSET_W]. When BLOCK_SIZE==4, the word select is empty and icache_data is the whole line.
- Lookup latency is 0 cycles: hit and data are combinational from icache_addr and the arrays.
- State IDLE:
  - On a hit, stay in IDLE.
  - On a miss, mem_req=1 in the same cycle. Next edge: latch fill address (aligned icache_addr), perf_miss_cnt += 1, go to FILL.
  - mem_ready is ignored in IDLE. This covers the IFU's lingering mem_ready after a completed refill.
- State FILL:
  - mem_req=0, icache_hit=0, icache_ready=0.
  - When mem_ready=1: write mem_data to data[fill idx], write the tag to tag[fill idx], set valid[fill idx]=1, go to IDLE.
  - The next cycle is a hit for the held address. Fill-to-hit turnaround is therefore 1 cycle after mem_ready.
- Flush:
  - Clears all valid bits on the next edge, in any state.
  - If a fill completes on the same edge, that line's valid is set. The fill wins for that index only. This prevents deadlock with an IFU waiting for a hit.
  - A flush during FILL does not abort the fill.
- Simultaneous miss and flush in IDLE: the refill still starts; the flush clears valids.
- icache_addr changing during FILL is a protocol violation. The cache uses the latched fill address for the install regardless.
- Reset mid-FILL: return to IDLE with all lines invalid. Any in-flight mem_ready after reset is ignored while IDLE.
- Single write port; no read/write hazard handling is needed, because lookups return hit=0 during FILL.

Decomposition:
- Shared config header (existing include) gets ICACHE_NUM_LINES and ICACHE_BLOCK_SIZE defaults, and the state encodings IDLE=1'b0, FILL=1'b1.
- One sub-module: ysyx_25020037_icache_array. It holds the tag/data storage with a combinational read on idx and a synchronous write (wen, widx, wtag, wdata). Valid bits stay in the top level so flush and reset are single-cycle.

Test Plan:
- Cold miss: reset, icache_addr=0x30000000 → mem_req=1, mem_addr=0x30000000, hit=0. Next cycle ready=0, perf_miss_cnt=1.
- Refill then hit: in FILL drive mem_data=0x00100093 with mem_ready=1 → next cycle hit=1, icache_data=0x00100093. mem_ready held 3 more cycles → no second refill, perf_miss_cnt stays 1.
- Conflict eviction (NUM_LINES=16, BLOCK_SIZE=4):
  - Fill 0x30000000, then access 0x30000040 (same idx 0) → miss and refill.
  - Return to 0x30000000 → miss again; perf_miss_cnt=3.
- Multi-word line (BLOCK_SIZE=16): fill block 0xA0000000 with words W0..W3 → addresses 0xA0000000/4/8/C each hit and return W0/W1/W2/W3.
- Flush: lines 0 and 1 valid, pulse flush → both addresses miss next cycle. Flush on the same edge as a fill's mem_ready → that filled line hits next cycle; the others miss.
- Async reset mid-FILL: assert rst between edges during FILL → ready=1 immediately, and a previously valid address misses after release.
